// File: rtl/uart_fifo_loopback_if.sv
// Serial pins, echo control and status of the UART loopback core.
// The core takes the slave side; whatever drives the pins takes the master side.
interface uart_fifo_loopback_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic        uart_rxd;
    logic        loop_en;
    logic        err_clr;
    logic        uart_txd;
    logic        tx_busy;
    logic [AW:0] fifo_level;
    logic        overflow;
    logic [7:0]  frame_err_cnt;
    logic [7:0]  parity_err_cnt;

    modport master (
        output uart_rxd, loop_en, err_clr,
        input  uart_txd, tx_busy, fifo_level, overflow, frame_err_cnt, parity_err_cnt
    );

    modport slave (
        input  uart_rxd, loop_en, err_clr,
        output uart_txd, tx_busy, fifo_level, overflow, frame_err_cnt, parity_err_cnt
    );
endinterface

// File: rtl/uart_fifo_loopback.sv
// UART receiver -> FIFO elastic buffer -> UART transmitter echo path.
// Frame format, parity, stop bits and buffer depth are parameters; errors are counted.
module uart_fifo_loopback #(
    parameter int CLK_FREQ   = 200_000_000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                sys_rst_n,
    uart_fifo_loopback_if.slave bus_io
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(STOP_BITS * BPS_CNT) + 1;
    localparam int BW      = $clog2(DATA_BITS) + 1;
    localparam logic [CW-1:0] HALF_END = CW'(BPS_CNT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * BPS_CNT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic                 rx_meta_q, rx_sync_q, rx_prev_q, rx_fall;
    state_t               rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d, rx_stop_q, rx_stop_d, rx_done_q, rx_done_d;
    logic                 rx_par_ok, rx_good;

    state_t               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, txd_q, txd_d;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] fifo_head;
    logic [AW:0]          wr_ptr_q, rd_ptr_q, level_q;
    logic                 fifo_full, fifo_empty, push, pop;
    logic                 overflow_q;
    logic [7:0]           frame_err_q, parity_err_q;

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus_io.uart_rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end
    assign rx_fall = rx_prev_q & ~rx_sync_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_stop_d  = rx_stop_q;
        rx_done_d  = 1'b0;
        unique case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_state_d = ST_START;
            end
            ST_START: if (rx_cnt_q == HALF_END) begin
                // A line that is high again at mid start bit was only a glitch.
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                rx_bit_d   = rx_bit_q + BW'(1);
                if (rx_bit_q == LAST_BIT) rx_state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d   = '0;
                rx_par_d   = rx_sync_q;
                rx_state_d = ST_STOP;
            end
            ST_STOP: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d   = '0;
                rx_stop_d  = rx_sync_q;
                rx_done_d  = 1'b1;
                rx_state_d = ST_IDLE;
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_stop_q  <= 1'b0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_stop_q  <= rx_stop_d;
            rx_done_q  <= rx_done_d;
        end
    end

    assign rx_par_ok = (PARITY == 0) ||
                       (rx_par_q == ((PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q));
    assign rx_good   = rx_done_q & rx_stop_q & rx_par_ok;

    // A full FIFO still accepts a frame when the transmitter pops in the same cycle.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = rx_good & (~fifo_full | pop);
    assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= rx_shift_q;
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n || bus_io.err_clr) begin
            frame_err_q  <= '0;
            parity_err_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (rx_done_q && !rx_stop_q && frame_err_q != 8'hFF) frame_err_q <= frame_err_q + 8'd1;
            if (rx_done_q && rx_stop_q && !rx_par_ok && parity_err_q != 8'hFF)
                parity_err_q <= parity_err_q + 8'd1;
            if (rx_good && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = 1'b1;
        pop        = 1'b0;
        unique case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                if (bus_io.loop_en && !fifo_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = fifo_head;
                    tx_par_d   = (PARITY == 1) ? ~^fifo_head : ^fifo_head;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                txd_d = 1'b0;
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                txd_d = tx_shift_q[0];
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + BW'(1);
                    if (tx_bit_q == LAST_BIT) tx_state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                txd_d = tx_par_q;
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_STOP;
                end
            end
            ST_STOP: if (tx_cnt_q == STOP_END) tx_state_d = ST_IDLE;
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    assign bus_io.uart_txd       = txd_q;
    assign bus_io.tx_busy        = (tx_state_q != ST_IDLE);
    assign bus_io.fifo_level     = level_q;
    assign bus_io.overflow       = overflow_q;
    assign bus_io.frame_err_cnt  = frame_err_q;
    assign bus_io.parity_err_cnt = parity_err_q;
endmodule

// File: tb/tb_uart_fifo_loopback.sv
// Directed bench for two loopback instances (8N1 and 7E2, depth 4, 10 clk per bit).
// Senders queue expected echoes; per-instance monitors decode uart_txd and compare.
module tb_uart_fifo_loopback;
    localparam int DBITS [2] = '{8, 7};
    localparam int PMODE [2] = '{0, 2};
    localparam int SBITS [2] = '{1, 2};

    typedef struct {
        logic [8:0] data;
        logic       par;
        int         t_ref;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic sys_rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_ign [2];
    exp_t exp_q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_fifo_loopback_if #(.FIFO_DEPTH(4)) bus_a ();
    uart_fifo_loopback_if #(.FIFO_DEPTH(4)) bus_b ();

    uart_fifo_loopback #(
        .CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (.clk(clk), .sys_rst_n(sys_rst_n), .bus_io(bus_a));

    uart_fifo_loopback #(
        .CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (.clk(clk), .sys_rst_n(sys_rst_n), .bus_io(bus_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic set_rxd(input int inst, input logic v);
        if (inst == 0) bus_a.uart_rxd = v;
        else           bus_b.uart_rxd = v;
    endtask

    function automatic logic txd_of(input int inst);
        return (inst == 0) ? bus_a.uart_txd : bus_b.uart_txd;
    endfunction

    task automatic drive_bit(input int inst, input logic v);
        set_rxd(inst, v);
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Must be called 1 time unit after a rising edge; lat=0 means no echo expected.
    task automatic send(input int inst, input logic [8:0] data, input bit flip_par,
                        input logic stop_val, input int lat);
        logic p;
        exp_t e;
        p = 1'b0;
        for (int i = 0; i < DBITS[inst]; i++) p = p ^ data[i];
        if (PMODE[inst] == 1) p = ~p;
        if (lat != 0) begin
            e.data  = data;
            e.par   = p;
            e.t_ref = cyc;
            e.lat   = lat;
            exp_q[inst].push_back(e);
        end
        $display("rx%0d send data=0x%0h stop=%0b parity_flip=%0b at cycle %0d",
                 inst, data, stop_val, flip_par, cyc);
        drive_bit(inst, 1'b0);
        for (int i = 0; i < DBITS[inst]; i++) drive_bit(inst, data[i]);
        if (PMODE[inst] != 0) drive_bit(inst, p ^ flip_par);
        drive_bit(inst, stop_val);
        set_rxd(inst, 1'b1);
    endtask

    task automatic monitor(input int inst);
        int         t_start;
        logic [8:0] d;
        logic       p;
        logic       stop_ok;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (txd_of(inst) == 1'b0) begin
                t_start = cyc;
                d       = '0;
                p       = 1'b0;
                stop_ok = 1'b1;
                repeat (4) @(negedge clk);
                for (int i = 0; i < DBITS[inst]; i++) begin
                    repeat (10) @(negedge clk);
                    d[i] = txd_of(inst);
                end
                if (PMODE[inst] != 0) begin
                    repeat (10) @(negedge clk);
                    p = txd_of(inst);
                end
                for (int i = 0; i < SBITS[inst]; i++) begin
                    repeat (10) @(negedge clk);
                    if (txd_of(inst) !== 1'b1) stop_ok = 1'b0;
                end
                if (!mon_ign[inst]) begin
                    $display("tx%0d echo data=0x%0h parity=%0b start cycle %0d", inst, d, p, t_start);
                    if (exp_q[inst].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame tx%0d: actual data=0x%0h required=no frame", inst, d);
                    end else begin
                        e = exp_q[inst].pop_front();
                        check("echo_data", d, e.data);
                        if (PMODE[inst] != 0) check("echo_parity", p, e.par);
                        check("echo_stop_bits", stop_ok, 1);
                        if (e.lat != 0) check("echo_start_latency", t_start - e.t_ref, e.lat);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 3000) begin
            align();
            n++;
        end
        check("scoreboard_drained", exp_q[0].size() + exp_q[1].size(), 0);
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (20) align();
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        mon_ign[0] = 1'b0;
        mon_ign[1] = 1'b0;
        sys_rst_n = 1'b0;
        bus_a.uart_rxd = 1'b1; bus_a.loop_en = 1'b1; bus_a.err_clr = 1'b0;
        bus_b.uart_rxd = 1'b1; bus_b.loop_en = 1'b1; bus_b.err_clr = 1'b0;
        repeat (4) align();
        @(negedge clk);
        check("rst_a_txd", bus_a.uart_txd, 1);
        check("rst_a_busy", bus_a.tx_busy, 0);
        check("rst_a_level", bus_a.fifo_level, 0);
        check("rst_a_overflow", bus_a.overflow, 0);
        check("rst_a_frame_err", bus_a.frame_err_cnt, 0);
        check("rst_b_parity_err", bus_b.parity_err_cnt, 0);
        check("rst_b_txd", bus_b.uart_txd, 1);
        align();
        sys_rst_n = 1'b1;
        repeat (3) align();

        // 8N1 echo of 0xA5 with level trace around the push/pop
        align();
        n0 = cyc;
        fork
            send(0, 9'h0A5, 1'b0, 1'b1, 101);
            begin
                wait_cyc(n0 + 98);
                check("a5_level_before_push", bus_a.fifo_level, 0);
                wait_cyc(n0 + 99);
                check("a5_level_after_push", bus_a.fifo_level, 1);
                wait_cyc(n0 + 100);
                check("a5_level_after_pop", bus_a.fifo_level, 0);
                check("a5_busy_after_pop", bus_a.tx_busy, 1);
            end
        join
        wait_drain();

        // Stop bit 0 -> frame error, then err_clr
        align();
        send(0, 9'h03C, 1'b0, 1'b0, 0);
        repeat (5) align();
        check("stop0_frame_err", bus_a.frame_err_cnt, 1);
        check("stop0_level", bus_a.fifo_level, 0);
        bus_a.err_clr = 1'b1;
        align();
        bus_a.err_clr = 1'b0;
        @(negedge clk);
        check("err_clr_frame_err", bus_a.frame_err_cnt, 0);

        // 4-clk glitch, then a normal frame proves RX is back in IDLE
        align();
        bus_a.uart_rxd = 1'b0;
        repeat (4) align();
        bus_a.uart_rxd = 1'b1;
        repeat (20) align();
        check("glitch_level", bus_a.fifo_level, 0);
        check("glitch_frame_err", bus_a.frame_err_cnt, 0);
        send(0, 9'h05A, 1'b0, 1'b1, 101);
        wait_drain();

        // Fill with transmitter held, overflow, then back-to-back drain
        bus_a.loop_en = 1'b0;
        align();
        for (int v = 1; v <= 4; v++) send(0, 9'(v), 1'b0, 1'b1, 0);
        check("fill4_level", bus_a.fifo_level, 4);
        check("fill4_overflow", bus_a.overflow, 0);
        send(0, 9'h005, 1'b0, 1'b1, 0);
        send(0, 9'h006, 1'b0, 1'b1, 0);
        check("fill6_level", bus_a.fifo_level, 4);
        check("fill6_overflow", bus_a.overflow, 1);
        align();
        n0 = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.data  = 9'(k + 1);
            e.par   = 1'b0;
            e.t_ref = n0;
            e.lat   = 2 + 101 * k;
            exp_q[0].push_back(e);
        end
        bus_a.loop_en = 1'b1;
        wait_drain();
        check("drain_level", bus_a.fifo_level, 0);

        // 7E2: parity 0 and parity 1 echoes queued back to back, then a parity error
        align();
        send(1, 9'h053, 1'b0, 1'b1, 101);
        send(1, 9'h007, 1'b0, 1'b1, 112);
        wait_drain();
        align();
        send(1, 9'h053, 1'b1, 1'b1, 0);
        repeat (5) align();
        check("par_flip_parity_err", bus_b.parity_err_cnt, 1);
        check("par_flip_frame_err", bus_b.frame_err_cnt, 0);
        check("par_flip_level", bus_b.fifo_level, 0);

        // Reset in the middle of transmitted data bit 3 of 0x77
        align();
        mon_ign[0] = 1'b1;
        send(0, 9'h077, 1'b0, 1'b1, 0);
        repeat (42) align();
        @(negedge clk);
        check("pre_rst_txd_bit3", bus_a.uart_txd, 0);
        check("pre_rst_busy", bus_a.tx_busy, 1);
        align();
        sys_rst_n = 1'b0;
        align();
        sys_rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_txd", bus_a.uart_txd, 1);
        check("mid_rst_busy", bus_a.tx_busy, 0);
        check("mid_rst_level", bus_a.fifo_level, 0);
        check("mid_rst_overflow", bus_a.overflow, 0);
        check("mid_rst_b_parity_err", bus_b.parity_err_cnt, 0);
        repeat (150) align();
        mon_ign[0] = 1'b0;
        repeat (150) align();
        check("post_rst_level", bus_a.fifo_level, 0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
